envase_stock_sched: RTL and testbench



---
 rtl/envase_stock_sched_pkg.sv | 16 +
 rtl/rr_arb2.sv | 21 ++
 rtl/sub8bit.sv | 21 ++
 rtl/envase_stock_sched.sv | 159 +++++++++++++++
 tb/tb_envase_stock_sched.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/envase_stock_sched_pkg.sv
// Shared definitions for the bottling-line stock scheduler.
//   state_e  : scheduler FSM states (IDLE -> CALC -> WB -> IDLE)
//   STOCK_W  : stock counter / amount width
//   NREQ     : number of consumers (0 = fill valve, 1 = capper)
package envase_stock_sched_pkg;

  localparam int unsigned STOCK_W = 8;
  localparam int unsigned NREQ    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_WB   = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter (purely combinational).
//   req   : request vector
//   ptr   : preferred requester when both are pending
//   grant : granted requester index
//   valid : at least one request pending
module rr_arb2
  import envase_stock_sched_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            ptr,
  output logic            grant,
  output logic            valid
);

  always_comb begin
    valid = |req;
    // A lone request is granted directly; a tie goes to the preferred one.
    grant = (req == 2'b11) ? ptr : req[1];
  end

endmodule

// File: rtl/sub8bit.sv
// 8-bit clamp-to-zero subtractor: s = a - b - bin, or 0 when it borrows.
//   a, b, bin : minuend, subtrahend, borrow-in
//   s         : clamped difference
//   bout      : borrow-out (difference would have been negative)
module sub8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  output logic [7:0] s,
  output logic       bout
);

  logic [8:0] diff;

  always_comb begin
    diff = {1'b0, a} - {1'b0, b} - {8'b0, bin};
    bout = diff[8];
    s    = bout ? '0 : diff[7:0];
  end

endmodule

// File: rtl/envase_stock_sched.sv
// Stock scheduler for the bottling line. Holds the volume (stock0) and cap
// (stock1) counters and shares one clamp-to-zero subtractor between the fill
// valve (requester 0) and the capper (requester 1), arbitrated round-robin.
//   clk, reset        : clock, synchronous active-high reset
//   load/load_sel/val : operator counter load (wins over a same-cycle write-back)
//   req, amt0, amt1   : consume requests (level, held until ack) and amounts
//   ack, short        : one-cycle completion pulse and shortage flag per requester
//   stock0, stock1    : stock counters
//   busy              : FSM not in IDLE
//   alarm             : low-stock flags (stock < LOW_THRESH), only when
//                       LOW_STOCK_ALARM_EN is defined; otherwise tied 0
module envase_stock_sched
  import envase_stock_sched_pkg::*;
#(
  parameter int unsigned LOW_THRESH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               load_sel,
  input  logic [STOCK_W-1:0] load_val,
  input  logic [NREQ-1:0]    req,
  input  logic [STOCK_W-1:0] amt0,
  input  logic [STOCK_W-1:0] amt1,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    short,
  output logic [STOCK_W-1:0] stock0,
  output logic [STOCK_W-1:0] stock1,
  output logic               busy,
  output logic [NREQ-1:0]    alarm
);

  state_e             state_q, state_d;
  logic               g_q, g_d;
  logic [STOCK_W-1:0] amt_q, amt_d;
  logic [STOCK_W-1:0] res_q, res_d;
  logic               bout_q, bout_d;
  logic               rr_q, rr_d;
  logic [STOCK_W-1:0] stock0_q, stock0_d;
  logic [STOCK_W-1:0] stock1_q, stock1_d;

  logic               arb_grant, arb_valid;
  logic [STOCK_W-1:0] sub_a, sub_s;
  logic               sub_bout;

  rr_arb2 u_arb (
    .req   (req),
    .ptr   (rr_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  assign sub_a = g_q ? stock1_q : stock0_q;

  sub8bit u_sub (
    .a    (sub_a),
    .b    (amt_q),
    .bin  (1'b0),
    .s    (sub_s),
    .bout (sub_bout)
  );

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    amt_d    = amt_q;
    res_d    = res_q;
    bout_d   = bout_q;
    rr_d     = rr_q;
    stock0_d = stock0_q;
    stock1_d = stock1_q;
    ack      = '0;
    short    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          g_d     = arb_grant;
          amt_d   = arb_grant ? amt1 : amt0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        res_d   = sub_s;
        bout_d  = sub_bout;
        state_d = ST_WB;
      end
      ST_WB: begin
        if (g_q) begin
          stock1_d = res_q;
          ack      = 2'b10;
          short    = {bout_q, 1'b0};
        end else begin
          stock0_d = res_q;
          ack      = 2'b01;
          short    = {1'b0, bout_q};
        end
        // Prefer the requester that was not just served.
        rr_d    = ~g_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Operator load overrides any write-back to the same counter.
    if (load) begin
      if (load_sel) stock1_d = load_val;
      else          stock0_d = load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      g_q      <= 1'b0;
      amt_q    <= '0;
      res_q    <= '0;
      bout_q   <= 1'b0;
      rr_q     <= 1'b0;
      stock0_q <= '0;
      stock1_q <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      amt_q    <= amt_d;
      res_q    <= res_d;
      bout_q   <= bout_d;
      rr_q     <= rr_d;
      stock0_q <= stock0_d;
      stock1_q <= stock1_d;
    end
  end

  assign stock0 = stock0_q;
  assign stock1 = stock1_q;
  assign busy   = (state_q != ST_IDLE);

`ifdef LOW_STOCK_ALARM_EN
  localparam logic [STOCK_W-1:0] THRESH = STOCK_W'(LOW_THRESH);

  logic [NREQ-1:0] alarm_q, alarm_d;

  always_comb begin
    alarm_d = {stock1_q < THRESH, stock0_q < THRESH};
  end

  always_ff @(posedge clk) begin
    if (reset) alarm_q <= '0;
    else       alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`else
  logic [STOCK_W-1:0] unused_thresh;
  assign unused_thresh = STOCK_W'(LOW_THRESH);
  assign alarm         = '0;
`endif

endmodule

// File: tb/tb_envase_stock_sched.sv
module tb_envase_stock_sched;

  localparam int THRESH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic       load_sel = 1'b0;
  logic [7:0] load_val = '0;
  logic [1:0] req = '0;
  logic [7:0] amt0 = '0;
  logic [7:0] amt1 = '0;
  logic [1:0] ack, short, alarm;
  logic [7:0] stock0, stock1;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  envase_stock_sched #(.LOW_THRESH(THRESH)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_sel (load_sel),
    .load_val (load_val),
    .req      (req),
    .amt0     (amt0),
    .amt1     (amt1),
    .ack      (ack),
    .short    (short),
    .stock0   (stock0),
    .stock1   (stock1),
    .busy     (busy),
    .alarm    (alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transaction is granted in an idle cycle, its result is taken from the
  // stock seen one cycle later, and it completes (ack + write) in the cycle after.
  int       m_stock[2];
  int       n_stock[2];
  bit       m_act = 1'b0;
  int       m_who, m_amt, m_age, m_res;
  bit       m_short;
  int       m_last = 1;
  bit [1:0] m_alarm = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_stock = '{0, 0};
      m_act   = 1'b0;
      m_last  = 1;
      m_alarm = '0;
    end else begin
`ifdef LOW_STOCK_ALARM_EN
      m_alarm = {m_stock[1] < THRESH, m_stock[0] < THRESH};
`endif
      n_stock = m_stock;
      if (m_act && m_age == 2) begin
        n_stock[m_who] = m_res;
        m_last = m_who;
        m_act  = 1'b0;
      end else if (m_act) begin
        if (m_amt > m_stock[m_who]) begin
          m_res = 0; m_short = 1'b1;
        end else begin
          m_res = m_stock[m_who] - m_amt; m_short = 1'b0;
        end
        m_age = 2;
      end else if (req != 2'b00) begin
        m_who = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
        m_amt = (m_who == 1) ? int'(amt1) : int'(amt0);
        m_act = 1'b1;
        m_age = 1;
      end
      if (load) n_stock[load_sel] = load_val;
      m_stock = n_stock;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int exp_ack;
      exp_ack = (m_act && m_age == 2) ? (1 << m_who) : 0;
      check("model_stock0", int'(stock0), m_stock[0]);
      check("model_stock1", int'(stock1), m_stock[1]);
      check("model_ack", int'(ack), exp_ack);
      check("model_busy", int'(busy), int'(m_act));
      check("model_alarm", int'(alarm), int'(m_alarm));
      if (exp_ack != 0)
        check("model_short", int'(short), m_short ? exp_ack : 0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic sel, input logic [7:0] val);
    load = 1'b1; load_sel = sel; load_val = val;
    tick();
    load = 1'b0;
  endtask

  // Raise req, wait (bounded) for the matching ack, drop req on that cycle,
  // then step into the following idle cycle so the write-back is visible.
  task automatic run_txn(input logic [1:0] r, input logic [7:0] a0, input logic [7:0] a1,
                         output int lat, output logic [1:0] sh);
    req = r; amt0 = a0; amt1 = a1; lat = -1; sh = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if ((ack & r) != 2'b00) begin
        lat = i; sh = short; req = '0;
        break;
      end
    end
    req = '0;
    tick();
  endtask

  int         lat;
  logic [1:0] sh;
  int         n;
  int         ack_cyc[4];
  logic [1:0] ack_seq[4];

  initial begin
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    check("reset_busy", int'(busy), 0);
    check("reset_stock0", int'(stock0), 0);
    check("reset_ack", int'(ack), 0);
    tick();
    reset = 1'b0;

    // 1: basic consume
    do_load(1'b0, 8'd50);
    run_txn(2'b01, 8'd20, 8'd0, lat, sh);
    check("t1_latency", lat, 2);
    check("t1_short", int'(sh), 0);
    check("t1_stock0", int'(stock0), 30);

    // 2: shortage clamps to zero
    do_load(1'b1, 8'd5);
    run_txn(2'b10, 8'd0, 8'd9, lat, sh);
    check("t2_latency", lat, 2);
    check("t2_short", int'(sh), 2);
    check("t2_stock1", int'(stock1), 0);

    // 3: both held, alternating grants every 3 cycles
    do_load(1'b0, 8'd100);
    do_load(1'b1, 8'd100);
    req = 2'b11; amt0 = 8'd10; amt1 = 8'd1; n = 0;
    for (int i = 1; i <= 20 && n < 4; i++) begin
      tick();
      if (ack != 2'b00) begin
        ack_seq[n] = ack; ack_cyc[n] = i; n++;
        if (n == 4) req = '0;
      end
    end
    req = '0;
    tick();
    check("t3_nacks", n, 4);
    check("t3_ack0_cyc", ack_cyc[0], 2);
    check("t3_ack1_cyc", ack_cyc[1], 5);
    check("t3_ack2_cyc", ack_cyc[2], 8);
    check("t3_ack3_cyc", ack_cyc[3], 11);
    check("t3_seq0", int'(ack_seq[0]), 1);
    check("t3_seq1", int'(ack_seq[1]), 2);
    check("t3_seq2", int'(ack_seq[2]), 1);
    check("t3_seq3", int'(ack_seq[3]), 2);
    check("t3_stock0", int'(stock0), 80);
    check("t3_stock1", int'(stock1), 98);

    // 4: amt == stock, then amt == 0
    do_load(1'b0, 8'd40);
    run_txn(2'b01, 8'd40, 8'd0, lat, sh);
    check("t4_eq_short", int'(sh), 0);
    check("t4_eq_stock0", int'(stock0), 0);
    run_txn(2'b01, 8'd0, 8'd0, lat, sh);
    check("t4_zero_lat", lat, 2);
    check("t4_zero_short", int'(sh), 0);
    check("t4_zero_stock0", int'(stock0), 0);

    // 5a: reset during CALC discards the transaction
    do_load(1'b0, 8'd60);
    req = 2'b01; amt0 = 8'd10;
    tick();
    check("t5_calc_busy", int'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; req = '0;
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_ack", int'(ack), 0);
    check("t5_rst_stock0", int'(stock0), 0);
    tick();
    check("t5_noack", int'(ack), 0);

    // 5b: load in WB to the granted counter wins
    do_load(1'b0, 8'd50);
    req = 2'b01; amt0 = 8'd5;
    tick();
    tick();
    check("t5_wb_ack", int'(ack), 1);
    load = 1'b1; load_sel = 1'b0; load_val = 8'd77; req = '0;
    tick();
    load = 1'b0;
    check("t5_wb_load", int'(stock0), 77);

    // 5c: load in the grant cycle feeds the subtraction
    req = 2'b10; amt1 = 8'd3;
    load = 1'b1; load_sel = 1'b1; load_val = 8'd20;
    tick();
    load = 1'b0;
    tick();
    check("t5_grant_ack", int'(ack), 2);
    req = '0;
    tick();
    check("t5_grant_stock1", int'(stock1), 17);

    // 6: low-stock alarm
    do_load(1'b0, 8'd8);
    tick();
    check("t6_alarm_at8", int'(alarm[0]), 0);
    run_txn(2'b01, 8'd1, 8'd0, lat, sh);
    check("t6_stock0", int'(stock0), 7);
    check("t6_alarm_same", int'(alarm[0]), 0);
    tick();
`ifdef LOW_STOCK_ALARM_EN
    check("t6_alarm_low", int'(alarm), 1);
`else
    check("t6_alarm_off", int'(alarm), 0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
